// File: rtl/bomb_pkg.sv
// Shared encodings for the bomb game: game FSM states, draw scheduler
// states, and the helper that derives the rejection mask from a range.
package bomb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ATIVATING  = 3'd1,
        ST_ATIVATED   = 3'd2,
        ST_DETONATING = 3'd3,
        ST_FAILED     = 3'd4,
        ST_SUCCESSED  = 3'd5
    } game_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } draw_state_t;

    // Draws are only allowed while the game is live; in IDLE the LFSR reseeds.
    function automatic logic is_serving(input logic [2:0] gs);
        return (gs == ST_ATIVATING) || (gs == ST_ATIVATED) || (gs == ST_DETONATING);
    endfunction

    // Smallest 2^k-1 that covers lim-1 (lim is 1..256).
    function automatic logic [7:0] mask_from_limit(input logic [8:0] lim);
        logic [7:0] m;
        logic [8:0] top;
        m   = '0;
        top = lim - 9'd1;
        for (int i = 0; i < 8; i++) begin
            if ({1'b0, m} < top) begin
                m = {m[6:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping around to index 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    // Scan N_REQ positions starting at ptr; keep only the first hit.
    always_comb begin
        int j;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any     = 1'b1;
                win[j]  = 1'b1;
                win_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rnd_draw_scheduler.sv
// Shares the LFSR word among N_REQ requesters: round-robin grant, then a
// mask-and-reject draw of a uniform value in [0, limit-1], with draws
// spaced DRAW_GAP cycles apart so each sees fresh LFSR bits.
module rnd_draw_scheduler
    import bomb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DRAW_GAP  = 8,
    parameter int MAX_TRIES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         current_state,
    input  logic [31:0]        rnd,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] limit,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         value,
    output logic               busy
);

    localparam int             IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [4:0]     GAP_MAX  = 5'(DRAW_GAP);
    localparam logic [3:0]     TRY_LAST = 4'(MAX_TRIES - 1);

    draw_state_t      state_reg, state_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [N_REQ-1:0] done_reg, done_next;
    logic [7:0]       value_reg, value_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [8:0]       lim_reg, lim_next;
    logic [7:0]       mask_reg, mask_next;
    logic [3:0]       tries_reg, tries_next;
    logic [4:0]       gap_reg, gap_next;

    logic [7:0]       limit_arr [N_REQ];
    logic [N_REQ-1:0] win;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             serve;
    logic             draw;
    logic             accept;
    logic [7:0]       sample;
    logic [8:0]       lim_new;
    logic             unused_rnd;

    // Only the top byte of the LFSR word feeds the draw.
    assign unused_rnd = ^rnd[23:0];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_limit
        assign limit_arr[gi] = limit[8*gi +: 8];
    end

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (rr_ptr_reg),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_any)
    );

    assign serve   = is_serving(current_state);
    assign lim_new = (limit_arr[win_idx] == 8'd0) ? 9'd256 : {1'b0, limit_arr[win_idx]};
    assign sample  = rnd[31:24] & mask_reg;
    assign accept  = ({1'b0, sample} < lim_reg);
    assign draw    = (state_reg == S_DRAW) && serve && (gap_reg == GAP_MAX);

    // Next-state and next-output logic for the grant/draw/done sequence.
    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        done_next   = '0;
        value_next  = value_reg;
        idx_next    = idx_reg;
        rr_ptr_next = rr_ptr_reg;
        lim_next    = lim_reg;
        mask_next   = mask_reg;
        tries_next  = tries_reg;

        if (!serve) begin
            gap_next = '0;
        end else if (draw) begin
            gap_next = '0;
        end else if (gap_reg < GAP_MAX) begin
            gap_next = gap_reg + 5'd1;
        end else begin
            gap_next = gap_reg;
        end

        case (state_reg)
            S_IDLE: begin
                if (serve && win_any) begin
                    gnt_next   = win;
                    idx_next   = win_idx;
                    lim_next   = lim_new;
                    mask_next  = mask_from_limit(lim_new);
                    tries_next = '0;
                    state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (!serve) begin
                    // Abort: drop the grant, keep value and pointer, retry later.
                    gnt_next   = '0;
                    state_next = S_IDLE;
                end else if (draw) begin
                    tries_next = tries_reg + 4'd1;
                    if (accept || (tries_reg == TRY_LAST)) begin
                        // Fallback s-lim stays in range because mask < 2*lim.
                        value_next         = accept ? sample : (sample - lim_reg[7:0]);
                        gnt_next           = '0;
                        done_next[idx_reg] = 1'b1;
                        state_next         = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rr_ptr_next = (idx_reg == IDX_W'(N_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);
                state_next  = S_IDLE;
            end
            default: begin
                gnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            gnt_reg    <= '0;
            done_reg   <= '0;
            value_reg  <= '0;
            idx_reg    <= '0;
            rr_ptr_reg <= '0;
            lim_reg    <= '0;
            mask_reg   <= '0;
            tries_reg  <= '0;
            gap_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            value_reg  <= value_next;
            idx_reg    <= idx_next;
            rr_ptr_reg <= rr_ptr_next;
            lim_reg    <= lim_next;
            mask_reg   <= mask_next;
            tries_reg  <= tries_next;
            gap_reg    <= gap_next;
        end
    end

    assign gnt   = gnt_reg;
    assign done  = done_reg;
    assign value = value_reg;
    assign busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_rnd_draw_scheduler.sv
// Directed bench for rnd_draw_scheduler: stimulus pushes expected done
// events into a scoreboard queue; a negedge monitor pops and compares.
module tb_rnd_draw_scheduler;

    localparam int N_REQ = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         cs;
    logic [31:0]        rnd;
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] limit;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [7:0]         value;
    logic               busy;

    typedef struct {
        int         idx;
        logic [7:0] val;
        int         cyc;   // -1: latency not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    rnd_draw_scheduler #(.N_REQ(N_REQ), .DRAW_GAP(8), .MAX_TRIES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .current_state (cs),
        .rnd           (rnd),
        .req           (req),
        .limit         (limit),
        .gnt           (gnt),
        .done          (done),
        .value         (value),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (done != '0)) begin
            $display("done=%b value=%02h cycle=%0d", done, value, cyc);
            if (sb.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("done_idx", int'(done), 1 << e.idx);
                chk("done_value", int'(value), int'(e.val));
                chk("gnt_clear_at_done", int'(gnt), 0);
                if (e.cyc >= 0) chk("done_latency", cyc, e.cyc);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect_done(input int idx, input logic [7:0] val, input int lat);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.cyc = (lat >= 0) ? cyc + lat : -1;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next done pulse; returns the served index.
    task automatic wait_done(output int idx);
        bit got;
        got = 1'b0;
        idx = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done != '0) begin
                got = 1'b1;
                for (int k = 0; k < N_REQ; k++) if (done[k]) idx = k;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int w;
        rst   = 1'b0;
        cs    = 3'd2;
        rnd   = 32'h0;
        req   = 4'hF;
        limit = '0;

        // 1. Reset held with all requests high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_value", int'(value), 0);
            chk("rst_busy", int'(busy), 0);
        end
        req = '0;
        rst = 1'b1;

        // 4. Round-robin: 0,1 then 3 ahead of re-asserted 0.
        rnd = 32'hAB00_0000;
        step(10);
        expect_done(0, 8'hAB, 2);
        expect_done(1, 8'hAB, -1);
        expect_done(3, 8'hAB, -1);
        expect_done(0, 8'hAB, -1);
        req = 4'b1011;
        wait_done(w); req[0] = 1'b0;
        wait_done(w); req[1] = 1'b0; req[0] = 1'b1;
        wait_done(w); req[3] = 1'b0;
        wait_done(w); req[0] = 1'b0;

        // 2. Accept path: limit 10, sample 5, done two cycles after request.
        limit[7:0] = 8'd10;
        rnd = 32'h0512_3456;
        step(10);
        expect_done(0, 8'h05, 2);
        req[0] = 1'b1;
        wait_done(w); req[0] = 1'b0;

        // 3. Reject then fallback: limit 5, mask 7, sample 7 twice -> 2.
        limit[7:0] = 8'd5;
        rnd = 32'h07FF_FFFF;
        step(10);
        expect_done(0, 8'h02, -1);
        req[0] = 1'b1;
        wait_done(w); req[0] = 1'b0;
        step(20);

        // 5. Abort mid-draw, then resume and complete.
        limit[23:16] = 8'd0;
        rnd = 32'h3C00_0000;
        cs = 3'd0;
        step(1);
        cs = 3'd2;
        expect_done(2, 8'h3C, -1);
        req[2] = 1'b1;
        step(1);
        chk("abort_gnt_before", int'(gnt), 4);
        chk("abort_busy_before", int'(busy), 1);
        cs = 3'd4;
        step(1);
        chk("abort_gnt_after", int'(gnt), 0);
        chk("abort_busy_after", int'(busy), 0);
        step(5);
        chk("abort_gnt_held_off", int'(gnt), 0);
        cs = 3'd2;
        wait_done(w); req[2] = 1'b0;

        // 6. limit 0 means 256; limit 1 always yields 0.
        limit[7:0] = 8'd0;
        rnd = 32'hC300_0000;
        step(10);
        expect_done(0, 8'hC3, 2);
        req[0] = 1'b1;
        wait_done(w); req[0] = 1'b0;
        limit[7:0] = 8'd1;
        step(10);
        expect_done(0, 8'h00, 2);
        req[0] = 1'b1;
        wait_done(w); req[0] = 1'b0;

        // Game IDLE: requests are never granted.
        cs  = 3'd0;
        req = 4'b0110;
        step(20);
        chk("idle_gnt", int'(gnt), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_value_held", int'(value), 0);
        req = '0;
        step(5);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
